// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM port arbiter.
// Arbiter states, requester ids and word aliases.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_D,
    GNT_I0,
    GNT_I1
  } arbState;

  localparam logic [1:0] REQ_D  = 2'd0;
  localparam logic [1:0] REQ_I0 = 2'd1;
  localparam logic [1:0] REQ_I1 = 2'd2;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick for the icache requesters.
// Pointer flips to the other core after each completed word.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_idx_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  // Next pointer: the core just served goes to the back.
  always_comb begin
    ptr_d = ptr_q;
    if (done_i) ptr_d = ~done_idx_i;
  end

  // Pointer register, core 0 first after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  // Single requester wins outright, ties go by pointer.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    unique case (req_i)
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ptr_q;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// RAM port arbiter: coherence D port plus two icaches.
// MEM_ARB_STARVE_GUARD_EN lets waiting icaches pre-empt D.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_store,
  output logic                d_wait,
  output logic [DATA_W-1:0]   d_load,
  input  logic [1:0]          i_ren,
  input  logic [2*ADDR_W-1:0] i_addr,
  output logic [1:0]          i_wait,
  output logic [2*DATA_W-1:0] i_load,
  output logic                ram_ren,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_store,
  input  logic [DATA_W-1:0]   ram_load,
  input  logic                ram_wait
);

  arbState state_q;

  logic d_req;
  logic i_any;
  logic i_done;
  logic pick_v;
  logic pick_idx;
  logic guard_hit;

  assign d_req = d_ren | d_wen;
  assign i_any = |i_ren;

  assign i_done =
    ((state_q == GNT_I0) & i_ren[0] & ~ram_wait) |
    ((state_q == GNT_I1) & i_ren[1] & ~ram_wait);

  rr_arbiter2 u_rr (
    .clk_i       (CLK),
    .rst_i       (RST),
    .req_i       (i_ren),
    .done_i      (i_done),
    .done_idx_i  (state_q == GNT_I1),
    .gnt_valid_o (pick_v),
    .gnt_idx_o   (pick_idx)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          d_entry, i_entry;

  assign guard_hit = (starve_q >= LIM) & i_any;
  assign d_entry   = (state_q == IDLE) & d_req & ~guard_hit;
  assign i_entry   = (state_q == IDLE) & ~d_entry & i_any;

  // Count D wins taken over a waiting icache, saturating.
  always_comb begin
    starve_d = starve_q;
    if (i_entry)
      starve_d = '0;
    else if (d_entry & i_any & (starve_q < LIM))
      starve_d = starve_q + CW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge CLK) begin
    if (RST) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic [31:0] unused_limit;
  assign unused_limit = STARVE_LIMIT;
  assign guard_hit    = 1'b0;
`endif

  // Grant FSM: D locks while requesting, icaches get one word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_req & ~guard_hit)
            state_q <= GNT_D;
          else if (pick_v)
            state_q <= pick_idx ? GNT_I1 : GNT_I0;
        end
        GNT_D: begin
          if (!d_req) state_q <= IDLE;
        end
        GNT_I0: begin
          if (!i_ren[0] || !ram_wait)
            state_q <= IDLE;
        end
        GNT_I1: begin
          if (!i_ren[1] || !ram_wait)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM mux and completion strobes for the granted requester.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    d_wait    = 1'b1;
    d_load    = '0;
    i_wait    = 2'b11;
    i_load    = '0;
    unique case (state_q)
      GNT_D: begin
        ram_addr  = d_addr;
        ram_store = d_store;
        ram_wen   = d_wen;
        ram_ren   = d_ren & ~d_wen;
        if (d_req && !ram_wait) begin
          d_wait = 1'b0;
          d_load = ram_load;
        end
      end
      GNT_I0: begin
        ram_addr = i_addr[ADDR_W-1:0];
        ram_ren  = i_ren[0];
        if (i_ren[0] && !ram_wait) begin
          i_wait[0]            = 1'b0;
          i_load[DATA_W-1:0]   = ram_load;
        end
      end
      GNT_I1: begin
        ram_addr = i_addr[2*ADDR_W-1:ADDR_W];
        ram_ren  = i_ren[1];
        if (i_ren[1] && !ram_wait) begin
          i_wait[1]                = 1'b0;
          i_load[2*DATA_W-1:DATA_W] = ram_load;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, random vs model,
// and a starvation sequence whose outcome depends on the macro.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SL    = 2;
  localparam bit GUARD = 1'b1;
`else
  localparam int SL    = 4;
  localparam bit GUARD = 1'b0;
`endif

  logic          CLK, RST;
  logic          d_ren, d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_store;
  logic          d_wait;
  logic [DW-1:0] d_load;
  logic [1:0]    i_ren;
  logic [2*AW-1:0] i_addr;
  logic [1:0]    i_wait;
  logic [2*DW-1:0] i_load;
  logic          ram_ren, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_store;
  logic [DW-1:0] ram_load;
  logic          ram_wait;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .d_ren(d_ren), .d_wen(d_wen),
    .d_addr(d_addr), .d_store(d_store),
    .d_wait(d_wait), .d_load(d_load),
    .i_ren(i_ren), .i_addr(i_addr),
    .i_wait(i_wait), .i_load(i_load),
    .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_wait(ram_wait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_fail;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          dr;
    bit          dw;
    bit [1:0]    ir;
    bit          rw;
    logic [31:0] da;
    bit          e_dw;
    bit [1:0]    e_iw;
    bit          e_ren;
    bit          e_wen;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t v(
    bit rst, bit dr, bit dw, bit [1:0] ir, bit rw,
    logic [31:0] da, bit edw, bit [1:0] eiw,
    bit eren, bit ewen, logic [31:0] ea);
    vec_t r;
    r.rst = rst; r.dr = dr; r.dw = dw; r.ir = ir;
    r.rw = rw; r.da = da; r.e_dw = edw; r.e_iw = eiw;
    r.e_ren = eren; r.e_wen = ewen; r.e_addr = ea;
    return r;
  endfunction

  vec_t tbl[30];

  task automatic step(bit dr, bit [1:0] ir, bit rw);
    @(posedge CLK); #1;
    RST = 1'b0; d_ren = dr; d_wen = 1'b0;
    i_ren = ir; ram_wait = rw;
    @(negedge CLK);
  endtask

  task automatic do_reset;
    @(posedge CLK); #1;
    RST = 1'b1; d_ren = 0; d_wen = 0; i_ren = 0;
    ram_wait = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Reference model state: current owner of the port.
  int owner;   // 0 none, 1 D, 2 I0, 3 I1
  bit rr;
  int stv;

  initial begin
    n_chk = 0; n_fail = 0;
    RST = 1; d_ren = 0; d_wen = 0; d_addr = 0;
    d_store = 32'h1234_5678; i_ren = 0;
    i_addr = {32'h180, 32'h100};
    ram_load = 32'hDEAD_BEEF; ram_wait = 0;

    tbl[0]  = v(1,0,0,2'b00,0,32'h200, 1,2'b11,0,0,0);
    tbl[1]  = v(0,0,0,2'b01,0,32'h200, 1,2'b11,0,0,0);
    tbl[2]  = v(0,0,0,2'b01,0,32'h200, 1,2'b10,1,0,32'h100);
    tbl[3]  = v(0,0,0,2'b00,0,32'h200, 1,2'b11,0,0,0);
    tbl[4]  = v(0,0,0,2'b11,0,32'h200, 1,2'b11,0,0,0);
    tbl[5]  = v(0,0,0,2'b11,0,32'h200, 1,2'b01,1,0,32'h180);
    tbl[6]  = v(0,0,0,2'b11,0,32'h200, 1,2'b11,0,0,0);
    tbl[7]  = v(0,0,0,2'b11,0,32'h200, 1,2'b10,1,0,32'h100);
    tbl[8]  = v(0,0,0,2'b11,0,32'h200, 1,2'b11,0,0,0);
    tbl[9]  = v(0,0,0,2'b11,0,32'h200, 1,2'b01,1,0,32'h180);
    tbl[10] = v(0,0,0,2'b00,0,32'h200, 1,2'b11,0,0,0);
    tbl[11] = v(0,1,0,2'b01,0,32'h200, 1,2'b11,0,0,0);
    tbl[12] = v(0,1,0,2'b01,0,32'h200, 0,2'b11,1,0,32'h200);
    tbl[13] = v(0,1,0,2'b01,0,32'h204, 0,2'b11,1,0,32'h204);
    tbl[14] = v(0,0,0,2'b01,0,32'h204, 1,2'b11,0,0,32'h204);
    tbl[15] = v(0,0,0,2'b01,0,32'h204, 1,2'b11,0,0,0);
    tbl[16] = v(0,0,0,2'b01,0,32'h204, 1,2'b10,1,0,32'h100);
    tbl[17] = v(0,0,0,2'b00,0,32'h200, 1,2'b11,0,0,0);
    tbl[18] = v(0,1,1,2'b00,1,32'h200, 1,2'b11,0,0,0);
    tbl[19] = v(0,1,1,2'b00,1,32'h200, 1,2'b11,0,1,32'h200);
    tbl[20] = v(0,1,1,2'b00,1,32'h200, 1,2'b11,0,1,32'h200);
    tbl[21] = v(0,1,1,2'b00,1,32'h200, 1,2'b11,0,1,32'h200);
    tbl[22] = v(0,1,1,2'b00,0,32'h200, 0,2'b11,0,1,32'h200);
    tbl[23] = v(0,0,0,2'b00,0,32'h200, 1,2'b11,0,0,32'h200);
    tbl[24] = v(0,0,0,2'b00,0,32'h200, 1,2'b11,0,0,0);
    tbl[25] = v(0,0,0,2'b10,1,32'h200, 1,2'b11,0,0,0);
    tbl[26] = v(0,0,0,2'b10,1,32'h200, 1,2'b11,1,0,32'h180);
    tbl[27] = v(1,0,0,2'b10,1,32'h200, 1,2'b11,1,0,32'h180);
    tbl[28] = v(0,0,0,2'b11,1,32'h200, 1,2'b11,0,0,0);
    tbl[29] = v(0,0,0,2'b11,0,32'h200, 1,2'b10,1,0,32'h100);

    @(posedge CLK); #1;
    @(posedge CLK); #1;

    for (int k = 0; k < 30; k++) begin
      @(posedge CLK); #1;
      RST = tbl[k].rst; d_ren = tbl[k].dr;
      d_wen = tbl[k].dw; i_ren = tbl[k].ir;
      ram_wait = tbl[k].rw; d_addr = tbl[k].da;
      @(negedge CLK);
      chk($sformatf("t%0d d_wait", k), d_wait, tbl[k].e_dw);
      chk($sformatf("t%0d i_wait", k), i_wait, tbl[k].e_iw);
      chk($sformatf("t%0d ram_ren", k), ram_ren, tbl[k].e_ren);
      chk($sformatf("t%0d ram_wen", k), ram_wen, tbl[k].e_wen);
      chk($sformatf("t%0d ram_addr", k), ram_addr,
          tbl[k].e_addr);
      if (tbl[k].e_wen)
        chk($sformatf("t%0d ram_store", k), ram_store,
            32'h1234_5678);
      if (!tbl[k].e_dw)
        chk($sformatf("t%0d d_load", k), d_load,
            32'hDEAD_BEEF);
      if (!tbl[k].e_iw[0])
        chk($sformatf("t%0d i_load0", k), i_load[31:0],
            32'hDEAD_BEEF);
      if (!tbl[k].e_iw[1])
        chk($sformatf("t%0d i_load1", k), i_load[63:32],
            32'hDEAD_BEEF);
    end

    // Random traffic against the transaction-level model.
    do_reset();
    owner = 0; rr = 0; stv = 0;
    for (int c = 0; c < 3000; c++) begin
      bit e_dw, e_ren, e_wen, done, dreq, anyi, pick, gh;
      bit [1:0] e_iw;
      logic [31:0] e_addr, e_st;
      int n;
      RST = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 3) == 0) d_ren = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) d_wen = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) i_ren = 2'($urandom);
      ram_wait = $urandom_range(0, 1);
      d_addr = $urandom; d_store = $urandom;
      i_addr = {$urandom, $urandom}; ram_load = $urandom;
      @(negedge CLK);

      e_dw = 1; e_iw = 2'b11; e_ren = 0; e_wen = 0;
      e_addr = 0; e_st = 0; done = 0; n = 0;
      dreq = d_ren | d_wen;
      if (owner == 1) begin
        e_addr = d_addr; e_st = d_store; e_wen = d_wen;
        e_ren = d_ren & ~d_wen;
        done = dreq & ~ram_wait; e_dw = ~done;
      end else if (owner >= 2) begin
        n = owner - 2;
        e_addr = i_addr[n*32 +: 32]; e_ren = i_ren[n];
        done = i_ren[n] & ~ram_wait; e_iw[n] = ~done;
      end
      chk("r d_wait", d_wait, e_dw);
      chk("r i_wait", i_wait, e_iw);
      chk("r ram_ren", ram_ren, e_ren);
      chk("r ram_wen", ram_wen, e_wen);
      chk("r ram_addr", ram_addr, e_addr);
      if (owner < 2) chk("r ram_store", ram_store, e_st);
      if (owner == 1 && done) chk("r d_load", d_load, ram_load);
      if (owner >= 2 && done)
        chk("r i_load", i_load[n*32 +: 32], ram_load);

      anyi = |i_ren;
      pick = (i_ren == 2'b11) ? rr : i_ren[1];
      gh = GUARD && (stv >= SL) && anyi;
      if (RST) begin
        owner = 0; rr = 0; stv = 0;
      end else if (owner == 0) begin
        if (dreq && !gh) begin
          owner = 1;
          if (anyi && stv < SL) stv++;
        end else if (anyi) begin
          owner = 2 + int'(pick); stv = 0;
        end
      end else if (owner == 1) begin
        if (!dreq) owner = 0;
      end else begin
        if (done) begin owner = 0; rr = ~n[0]; end
        else if (!i_ren[n]) owner = 0;
      end
      @(posedge CLK); #1;
    end

    // D keeps re-arbitrating while I1 waits.
    do_reset();
    d_addr = 32'h300; ram_load = 32'hCAFE_0001;
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    chk("s d_word1", d_wait, 1'b0);
    step(0, 2'b10, 0);
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    chk("s d_word2", d_wait, 1'b0);
    step(0, 2'b10, 0);
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    if (GUARD) begin
      chk("s guard i_wait", i_wait, 2'b01);
      chk("s guard d_wait", d_wait, 1'b1);
    end else begin
      chk("s nog i_wait", i_wait, 2'b11);
      chk("s nog d_wait", d_wait, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
